// File: rtl/fft_pkg.sv
// Shared defaults, sample type, FSM state enums and bit-reverse helper for the FFT input path.
// The optional bit-reversed write addressing is selected with FFT_REORDER_BITREV_EN.
package fft_pkg;

    localparam int N_DEF     = 256;
    localparam int LOG2N_DEF = 8;
    localparam int DW_DEF    = 8;

    typedef struct packed {
        logic [DW_DEF-1:0] re;
        logic [DW_DEF-1:0] im;
    } sample_t;

    typedef enum logic {WR_FILL, WR_WAIT} wr_state_e;
    typedef enum logic {RD_IDLE, RD_STREAM} rd_state_e;

    // Reverses the low 'bits' bits of k; higher result bits stay zero.
    function automatic logic [15:0] bitrev(input logic [15:0] k, input int bits);
        logic [15:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            if (i < bits) r[i] = k[bits-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_pingpong_ram.sv
// Two-bank sample memory: one write port, one registered read port whose output
// register doubles as the stream output register (holds when rd_en_i is low).
module fft_pingpong_ram #(
    parameter int DEPTH = 256,
    parameter int AW    = 8,
    parameter int W     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic          wr_bank_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [W-1:0]  wr_data_i,
    input  logic          rd_en_i,
    input  logic          rd_bank_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [W-1:0]  rd_data_o
);

    logic [W-1:0] mem0 [DEPTH];
    logic [W-1:0] mem1 [DEPTH];
    logic [W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            if (wr_bank_i) mem1[wr_addr_i] <= wr_data_i;
            else           mem0[wr_addr_i] <= wr_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_bank_i ? mem1[rd_addr_i] : mem0[rd_addr_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/fft_input_reorder.sv
// Ping-pong frame buffer that replays each N-point frame in bit-reversed order when
// FFT_REORDER_BITREV_EN is defined, or in natural order otherwise.
module fft_input_reorder
    import fft_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int LOG2N = LOG2N_DEF,
    parameter int DW    = DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_re,
    input  logic [DW-1:0] s_im,
    input  logic          s_last,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_re,
    output logic [DW-1:0] m_im,
    output logic          m_first,
    output logic          m_last,
    output logic          frame_err
);

    localparam logic [LOG2N-1:0] LAST_IDX = LOG2N'(N - 1);

    wr_state_e        wr_state_q, wr_state_d;
    rd_state_e        rd_state_q, rd_state_d;
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [LOG2N-1:0] wr_cnt_q, wr_cnt_d;
    logic [LOG2N-1:0] rd_cnt_q, rd_cnt_d;
    logic [1:0]       full_q, full_d;
    logic             m_valid_q, m_valid_d;
    logic             m_first_q, m_first_d;
    logic             m_last_q, m_last_d;
    logic             frame_err_q, frame_err_d;

    logic             sAccept, canRead, rdLoad, wrWrap, rdWrap;
    logic [1:0]       setFull, clrFull;
    logic [LOG2N-1:0] wrAddr;
    logic [2*DW-1:0]  rdData;

`ifdef FFT_REORDER_BITREV_EN
    assign wrAddr = LOG2N'(bitrev(16'(wr_cnt_q), LOG2N));
`else
    assign wrAddr = wr_cnt_q;
`endif

    assign s_ready = (wr_state_q == WR_FILL);
    assign sAccept = s_valid && s_ready;
    // Reading may start in the same cycle the bank is seen full, which gives t+2 latency.
    assign canRead = (rd_state_q == RD_STREAM) || full_q[rd_bank_q];
    assign rdLoad  = canRead && (!m_valid_q || m_ready);
    assign wrWrap  = sAccept && (wr_cnt_q == LAST_IDX);
    assign rdWrap  = rdLoad && (rd_cnt_q == LAST_IDX);

    fft_pingpong_ram #(.DEPTH(N), .AW(LOG2N), .W(2*DW)) u_ram (
        .clk       (clk),
        .rst       (rst),
        .we_i      (sAccept),
        .wr_bank_i (wr_bank_q),
        .wr_addr_i (wrAddr),
        .wr_data_i ({s_re, s_im}),
        .rd_en_i   (rdLoad),
        .rd_bank_i (rd_bank_q),
        .rd_addr_i (rd_cnt_q),
        .rd_data_o (rdData)
    );

    always_comb begin
        wr_state_d  = wr_state_q;
        rd_state_d  = rd_state_q;
        wr_bank_d   = wr_bank_q;
        rd_bank_d   = rd_bank_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        m_valid_d   = m_valid_q;
        m_first_d   = m_first_q;
        m_last_d    = m_last_q;
        setFull     = '0;
        clrFull     = '0;
        frame_err_d = sAccept && (s_last != (wr_cnt_q == LAST_IDX));

        if (sAccept) wr_cnt_d = wr_cnt_q + 1'b1;
        if (wrWrap) begin
            setFull[wr_bank_q] = 1'b1;
            wr_bank_d          = ~wr_bank_q;
        end

        if (rdLoad) begin
            rd_cnt_d  = rd_cnt_q + 1'b1;
            m_valid_d = 1'b1;
            m_first_d = (rd_cnt_q == '0);
            m_last_d  = (rd_cnt_q == LAST_IDX);
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
        if (rdWrap) begin
            clrFull[rd_bank_q] = 1'b1;
            rd_bank_d          = ~rd_bank_q;
        end

        full_d = (full_q & ~clrFull) | setFull;

        // Using full_d lets a bank freed on the same edge be refilled without a stall.
        case (wr_state_q)
            WR_FILL: if (wrWrap && full_d[wr_bank_d]) wr_state_d = WR_WAIT;
            WR_WAIT: if (!full_q[wr_bank_q]) wr_state_d = WR_FILL;
            default: wr_state_d = WR_FILL;
        endcase

        case (rd_state_q)
            RD_IDLE:   if (full_q[rd_bank_q]) rd_state_d = RD_STREAM;
            RD_STREAM: if (rdWrap) rd_state_d = full_d[rd_bank_d] ? RD_STREAM : RD_IDLE;
            default:   rd_state_d = RD_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_state_q  <= WR_FILL;
            rd_state_q  <= RD_IDLE;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            full_q      <= '0;
            m_valid_q   <= 1'b0;
            m_first_q   <= 1'b0;
            m_last_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            wr_state_q  <= wr_state_d;
            rd_state_q  <= rd_state_d;
            wr_bank_q   <= wr_bank_d;
            rd_bank_q   <= rd_bank_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            full_q      <= full_d;
            m_valid_q   <= m_valid_d;
            m_first_q   <= m_first_d;
            m_last_q    <= m_last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign m_valid   = m_valid_q;
    assign m_first   = m_first_q;
    assign m_last    = m_last_q;
    assign frame_err = frame_err_q;
    assign m_re      = rdData[2*DW-1:DW];
    assign m_im      = rdData[DW-1:0];

endmodule

// File: tb/tb_fft_input_reorder.sv
// Self-checking bench for fft_input_reorder: frame-level reference model plus table and
// hand-written corner sequences; expected order follows FFT_REORDER_BITREV_EN.
module tb_fft_input_reorder;
    import fft_pkg::*;

    localparam int N     = N_DEF;
    localparam int LOG2N = LOG2N_DEF;
    localparam int DW    = DW_DEF;

    typedef struct {
        sample_t s;
        bit      first;
        bit      last;
    } out_t;

    typedef struct {
        int          j;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        bit          first;
        bit          last;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid, s_ready, s_last;
    logic [DW-1:0] s_re, s_im;
    logic          m_valid, m_ready, m_first, m_last, frame_err;
    logic [DW-1:0] m_re, m_im;

    int   checks = 0;
    int   errors = 0;
    int   cycle = 0;
    int   wrCount = 0;
    int   errPulses = 0;
    int   outCount = 0;
    int   lastInCycle = -1;
    int   firstValidCycle = -1;
    bit   errExpect = 1'b0;
    bit   randReady = 1'b0;
    logic readyCmd = 1'b0;
    sample_t frameBuf [N];
    out_t    expQ [$];
    out_t    outLog [$];
    vec_t    vecs [$];

    fft_input_reorder dut (
        .clk       (clk),
        .rst       (rst),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_re      (s_re),
        .s_im      (s_im),
        .s_last    (s_last),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_re      (m_re),
        .m_im      (m_im),
        .m_first   (m_first),
        .m_last    (m_last),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    always @(posedge clk) begin
        #2;
        m_ready = randReady ? 1'($urandom_range(0, 1)) : readyCmd;
    end

    function automatic int bitrevIdx(input int k);
        int r = 0;
        int v = k;
        for (int i = 0; i < LOG2N; i++) begin
            r = r * 2 + (v % 2);
            v = v / 2;
        end
        return r;
    endfunction

    function automatic int srcIndex(input int j);
`ifdef FFT_REORDER_BITREV_EN
        return bitrevIdx(j);
`else
        return j;
`endif
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cycle);
        end
    endtask

    // Reference model and scoreboard: frames close purely on the count of accepted samples.
    always @(negedge clk) begin
        out_t e;
        if (rst) begin
            wrCount   = 0;
            errExpect = 1'b0;
            expQ.delete();
        end else begin
            checkOutput("frame_err", 32'(frame_err), 32'(errExpect));
            if (frame_err) errPulses++;
            errExpect = 1'b0;
            if (s_valid && s_ready) begin
                errExpect = (s_last != (wrCount == N - 1));
                frameBuf[wrCount] = '{re: s_re, im: s_im};
                wrCount++;
                if (wrCount == N) begin
                    wrCount = 0;
                    if (lastInCycle < 0) lastInCycle = cycle;
                    for (int j = 0; j < N; j++) begin
                        e.s     = frameBuf[srcIndex(j)];
                        e.first = (j == 0);
                        e.last  = (j == N - 1);
                        expQ.push_back(e);
                    end
                end
            end
            if (m_valid && firstValidCycle < 0) firstValidCycle = cycle;
            if (m_valid) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_output: got re=0x%0h im=0x%0h, expected no valid output", m_re, m_im);
                end else begin
                    checkOutput("m_re", 32'(m_re), 32'(expQ[0].s.re));
                    checkOutput("m_im", 32'(m_im), 32'(expQ[0].s.im));
                    checkOutput("m_first", 32'(m_first), 32'(expQ[0].first));
                    checkOutput("m_last", 32'(m_last), 32'(expQ[0].last));
                    if (m_ready) begin
                        e.s     = '{re: m_re, im: m_im};
                        e.first = m_first;
                        e.last  = m_last;
                        outLog.push_back(e);
                        outCount++;
                        void'(expQ.pop_front());
                    end
                end
            end
        end
    end

    task automatic applyStimulus(input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        bit acc;
        int guard;
        guard   = 0;
        s_valid = 1'b1;
        s_re    = re;
        s_im    = im;
        s_last  = last;
        do begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!acc && guard < 5000);
        if (!acc) begin
            checks++;
            errors++;
            $display("[TB] FAIL input_timeout: got s_ready=0 for %0d cycles, expected acceptance", guard);
        end
        s_valid = 1'b0;
    endtask

    // mode 0: ramp re=k, im=-k; mode 1: random data.
    task automatic sendFrame(input int mode, input int lastA, input int lastB, input int gapPct);
        logic [DW-1:0] kk;
        for (int k = 0; k < N; k++) begin
            while (gapPct > 0 && $urandom_range(0, 99) < gapPct) begin
                @(posedge clk);
                #1;
            end
            kk = DW'(k);
            if (mode == 0) applyStimulus(kk, -kk, (k == lastA) || (k == lastB));
            else applyStimulus(DW'($urandom), DW'($urandom), (k == lastA) || (k == lastB));
        end
    endtask

    task automatic waitDrain(input string name, input int limit);
        int guard;
        guard = 0;
        while ((expQ.size() != 0 || wrCount != 0) && guard < limit) begin
            @(negedge clk);
            #1;
            guard++;
        end
        checkOutput(name, 32'(expQ.size()), 32'd0);
    endtask

    initial begin
        int base;
        int guard;
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_re     = '0;
        s_im     = '0;
        s_last   = 1'b0;
        readyCmd = 1'b1;

`ifdef FFT_REORDER_BITREV_EN
        vecs = '{'{0, 8'h00, 8'h00, 1, 0}, '{1, 8'h80, 8'h80, 0, 0}, '{2, 8'h40, 8'hC0, 0, 0},
                 '{3, 8'hC0, 8'h40, 0, 0}, '{128, 8'h01, 8'hFF, 0, 0}, '{255, 8'hFF, 8'h01, 0, 1}};
`else
        vecs = '{'{0, 8'h00, 8'h00, 1, 0}, '{1, 8'h01, 8'hFF, 0, 0}, '{2, 8'h02, 8'hFE, 0, 0},
                 '{3, 8'h03, 8'hFD, 0, 0}, '{128, 8'h80, 8'h80, 0, 0}, '{255, 8'hFF, 8'h01, 0, 1}};
`endif

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("reset_s_ready", 32'(s_ready), 32'd1);
        checkOutput("reset_m_valid", 32'(m_valid), 32'd0);
        checkOutput("reset_frame_err", 32'(frame_err), 32'd0);
        checkOutput("reset_m_re", 32'(m_re), 32'd0);
        checkOutput("reset_m_first", 32'(m_first), 32'd0);
        checkOutput("reset_m_last", 32'(m_last), 32'd0);

        $display("[TB] ramp frames, m_ready held high");
        outLog.delete();
        sendFrame(0, N - 1, -1, 0);
        sendFrame(0, N - 1, -1, 0);
        waitDrain("ramp_drain", 2000);
        checkOutput("ramp_count", 32'(outLog.size()), 32'(2 * N));
        checkOutput("ramp_latency", 32'(firstValidCycle - lastInCycle), 32'd2);
        for (int v = 0; v < vecs.size(); v++) begin
            if (outLog.size() > vecs[v].j) begin
                checkOutput($sformatf("table_re[%0d]", vecs[v].j), 32'(outLog[vecs[v].j].s.re), 32'(vecs[v].re));
                checkOutput($sformatf("table_im[%0d]", vecs[v].j), 32'(outLog[vecs[v].j].s.im), 32'(vecs[v].im));
                checkOutput($sformatf("table_first[%0d]", vecs[v].j), 32'(outLog[vecs[v].j].first), 32'(vecs[v].first));
                checkOutput($sformatf("table_last[%0d]", vecs[v].j), 32'(outLog[vecs[v].j].last), 32'(vecs[v].last));
            end
        end

        $display("[TB] backpressure: two frames stored, third waits");
        readyCmd = 1'b0;
        @(posedge clk);
        #1;
        sendFrame(0, N - 1, -1, 0);
        sendFrame(1, N - 1, -1, 0);
        checkOutput("full_s_ready", 32'(s_ready), 32'd0);
        s_valid  = 1'b1;
        s_re     = 8'h5A;
        s_im     = 8'hA5;
        s_last   = 1'b0;
        readyCmd = 1'b1;
        base     = outCount;
        guard    = 0;
        do begin
            @(negedge clk);
            #1;
            guard++;
        end while (!s_ready && guard < 3000);
        checkOutput("ready_return_outputs", 32'(outCount - base), 32'(N + 1));
        @(posedge clk);
        #1;
        s_valid = 1'b0;
        for (int k = 1; k < N; k++) applyStimulus(DW'($urandom), DW'($urandom), k == N - 1);
        waitDrain("backpressure_drain", 4000);

        $display("[TB] random m_ready and input gaps");
        base      = outCount;
        randReady = 1'b1;
        sendFrame(1, N - 1, -1, 30);
        sendFrame(1, N - 1, -1, 30);
        waitDrain("random_drain", 6000);
        randReady = 1'b0;
        checkOutput("random_count", 32'(outCount - base), 32'(2 * N));

        $display("[TB] early s_last");
        @(posedge clk);
        #1;
        errPulses = 0;
        sendFrame(0, 100, N - 1, 0);
        waitDrain("early_last_drain", 2000);
        checkOutput("early_last_pulses", 32'(errPulses), 32'd1);

        $display("[TB] reset mid-frame");
        for (int k = 0; k < 40; k++) applyStimulus(8'h55, 8'h33, 1'b0);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("post_reset_s_ready", 32'(s_ready), 32'd1);
        checkOutput("post_reset_m_valid", 32'(m_valid), 32'd0);
        outLog.delete();
        sendFrame(0, N - 1, -1, 0);
        waitDrain("post_reset_drain", 2000);
        checkOutput("post_reset_count", 32'(outLog.size()), 32'(N));
        if (outLog.size() > 0) begin
            checkOutput("post_reset_first_re", 32'(outLog[0].s.re), 32'd0);
            checkOutput("post_reset_first_flag", 32'(outLog[0].first), 32'd1);
        end

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/fft_input_reorder.md
# fft_input_reorder

Streaming front end for the one-dimensional FFT path. It accepts signed 8-bit complex samples one per handshake and assembles them into N-point frames in a two-bank ping-pong buffer. It replays each completed frame in bit-reversed index order, so the downstream FFT stage receives its operands in butterfly-ready order. One bank fills while the other drains, so steady-state throughput is one sample per clock.

## Interface
- N, 256, points per frame; power of two, ≥ 4
- LOG2N, 8, log2(N); drives counter and address widths
- DW, 8, bits per real/imag component, two's complement
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- s_valid  in  1  input sample valid
- s_ready  out  1  block can accept a sample
- s_re  in  DW  input real part
- s_im  in  DW  input imaginary part
- s_last  in  1  producer marks last sample of its frame; checked only
- m_valid  out  1  output sample valid
- m_ready  in  1  downstream accepts
- m_re  out  DW  output real part
- m_im  out  DW  output imaginary part
- m_first  out  1  output sample is index 0 of a frame
- m_last  out  1  output sample is index N-1 of a frame
- frame_err  out  1  one-cycle pulse on an s_last mismatch

## Operation
- Transfer occurs on a cycle where valid and ready are both high. Data is sampled only on transfer.
- Storage: bank 0 and bank 1, each N × (2·DW). Per-bank flag full[b].
- **Write side** holds wr_bank and a wr_cnt counter (LOG2N bits).
  - Each accepted sample is stored at address f(wr_cnt), then wr_cnt increments.
  - When wr_cnt = N-1 is accepted, wr_cnt wraps to 0, full[wr_bank] is set, and wr_bank toggles.
- **Write FSM**
  - WR_FILL: s_ready = 1 while !full[wr_bank].
  - WR_WAIT: entered when the target bank is full; s_ready = 0. Returns to WR_FILL the cycle after that bank's full flag clears.
- **Read side** holds rd_bank and a rd_cnt counter.
  - RD_IDLE: waits until full[rd_bank] = 1, then moves to RD_STREAM.
  - RD_STREAM: a one-entry output register is loaded from address rd_cnt whenever it is empty or being consumed this cycle.
  - After loading index N-1, the block clears full[rd_bank], toggles rd_bank, and returns to RD_IDLE. Lookahead: if the other bank is already full, it goes straight to the next frame with no bubble.
- m_first = (loaded index == 0); m_last = (loaded index == N-1).
- **s_last check:** frame_err pulses the cycle after a transfer where s_last ≠ (wr_cnt == N-1). The frame still closes on the count alone; s_last never resynchronises the counter.
- **Simultaneous events:** setting full for one bank and clearing full for the other in the same cycle are independent. A write to bank b and a read of bank ¬b in the same cycle never conflict.
- Data passes through bit-exact. No arithmetic, rounding or saturation.

## Timing
- Reset values:
  - Outputs: s_ready = 1, m_valid = 0, m_first = 0, m_last = 0, m_re = 0, m_im = 0, frame_err = 0.
  - Internal: wr_bank = rd_bank = 0, counters = 0, full = 00, FSMs in WR_FILL / RD_IDLE.
- Latency: the last input transfer occurs in cycle t. full is set at the t+1 edge, and m_valid with index 0 is high in cycle t+2.
- The output register holds m_* stable while m_valid && !m_ready.
- Sustained input at 1 sample/clock with m_ready = 1 never deasserts s_ready.
- A reset mid-frame discards every partial and full bank. The first post-reset sample is index 0 of bank 0.
- s_ready is registered, not combinationally dependent on m_ready.

## Configuration
- FFT_REORDER_BITREV_EN defined: write address f(k) = bit-reverse of k over LOG2N bits, and the read side reads sequentially. Output index j carries input sample bitrev(j).
- Not defined: f(k) = k. Frames pass in natural order and the block acts as a pure ping-pong frame buffer. Latency and handshakes are identical.

## Structure
- A shared package fft_pkg holds N, LOG2N and DW defaults, the sample struct {re, im}, the wr/rd FSM state enums, and a bitrev function.
- One sub-module: fft_pingpong_ram, a two-bank, one-write / one-registered-read memory. The write side, read side and flags stay in the top level.

## Test plan
- Reset, then an idle cycle: s_ready = 1, m_valid = 0, frame_err = 0.
- With BITREV_EN and N = 256, send a ramp re = k, im = −k, s_last at k = 255, and hold m_ready = 1.
  - Output j = 1 gives re = −128 (0x80), im = −128. Output j = 2 gives re = 64, im = −64.
  - m_first is set at j = 0, m_last at j = 255, and m_valid first rises 2 cycles after the last input.
- Send 3 back-to-back frames with m_ready = 0 throughout.
  - Frames 1 and 2 are accepted, then s_ready = 0 after input index 511.
  - Release m_ready: frame 1 drains, and s_ready returns 1 cycle after bank 0 frees.
- Toggle m_ready randomly at 50%: the output sequence stays complete and in order, with no duplicates and no m_* change while stalled.
- Assert s_last at k = 100: frame_err pulses once, and the frame still closes at k = 255.
- Assert rst at input index 40, then send a full frame: the output is that frame only, and m_re = 0 appears on the first output.
